load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles spent in REQ+WAIT before abort (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request from control; sampled only in IDLE.
REQ-005 is_store  in  1  1=store, 0=load.
REQ-006 size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-007 load_unsigned  in  1  1=zero-extend the load result, 0=sign-extend it.
REQ-008 addr  in  32  effective address, taken from the ALU out result.
REQ-009 wdata  in  32  store data (rs2).
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 rdata  out  32  aligned, extended load result; valid from done onward.
REQ-013 misaligned  out  1  asserted only with done; reports an alignment/size error.
REQ-014 bus_err  out  1  asserted only with done; reports a timeout abort.
REQ-015 mem_req/mem_we  out  1/1; mem_addr  out  32  word-aligned (bits[1:0]=0); mem_be  out  4; mem_wdata  out  32.
REQ-016 mem_gnt  in  1; mem_rvalid  in  1; mem_rdata  in  32.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, RESP.
- IDLE + start: capture all request inputs.
- Aligned request: go to REQ.
- Misaligned request: go to RESP with no memory request.
REQ-018 In REQ, mem_req SHALL stay high with stable mem_* outputs until the mem_gnt cycle.
- Store + gnt: go to RESP.
- Load + gnt: go to WAIT.
REQ-019 In WAIT, the FSM SHALL capture mem_rdata on mem_rvalid and go to RESP.
REQ-020 In RESP, done SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
- start in RESP is ignored.
REQ-021 Latency SHALL be: start at T, gnt at T+1 -> store done at T+2; load with rvalid at T+2 -> done at T+3.
REQ-022 mem_be SHALL be:
- byte: 4'b0001<<addr[1:0]
- half: 4'b0011<<addr[1:0]
- word: 4'b1111
REQ-023 mem_wdata SHALL replicate the data across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-024 Misaligned SHALL mean: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
REQ-025 Load data SHALL be mem_rdata>>(8*addr[1:0]), then zero- or sign-extended from bit 7 (byte) or bit 15 (half).
REQ-026 rdata SHALL hold its value until the next successful load.
- Stores and errored operations leave rdata unchanged.
REQ-027 mem_rvalid and mem_gnt outside REQ/WAIT SHALL be ignored.
REQ-028 mem_we SHALL equal the captured is_store while mem_req=1, and 0 otherwise.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and zero every output, including rdata, from any state.
- mem_req therefore drops asynchronously mid-transaction.
REQ-030 After reset release, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-031 With LSU_TIMEOUT_EN defined:
- A counter runs in REQ/WAIT.
- On reaching TIMEOUT_CYCLES, the FSM goes to RESP with bus_err=1 and mem_req dropped.
REQ-032 Without LSU_TIMEOUT_EN, there SHALL be no counter and bus_err SHALL be tied 0; REQ/WAIT wait indefinitely.

Structure
REQ-033 Package lsu_pkg SHALL hold the size codes, the FSM state enum, and the byte-lane constants.
REQ-034 Lane steering and extension SHALL live in a combinational sub-module lsu_lane_align.

Verification
REQ-035 Store byte: addr=0x1003, wdata=0xAB, gnt at T+1 -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB, done at T+2.
REQ-036 Load half signed: addr=0x2002, mem_rdata=0x8001_1234, rvalid at T+2 -> rdata=0xFFFF8001, done at T+3.
REQ-037 Load word, addr=0x3001 -> no mem_req, done+misaligned at T+1, rdata unchanged.
REQ-038 gnt held low 5 cycles -> mem_req and all mem_* outputs stable for 5 cycles; start pulses during busy are ignored.
REQ-039 rst_n low while in WAIT -> mem_req=0, busy=0, rdata=0 immediately; a following load completes normally.
REQ-040 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no gnt -> done+bus_err after 4 REQ cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
// Holds the access-size codes, the control FSM state enum, the byte-lane
// enable constants and the alignment rule used when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  // Byte-lane enables before shifting by the address offset
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // An access is unusable when it straddles its natural boundary or the
  // size code is the reserved one.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offs);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offs[0];
      SIZE_WORD: mis = (offs != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational byte-lane steering.
// Store side: byte enables and lane-replicated write data for a request.
// Load side: shift the returned word down to the addressed lane and
// zero- or sign-extend byte/half results to 32 bits.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_offs,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_offs,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift_s;
  logic        ld_sign_s;

  // Byte enables and replicated write data for the outgoing request
  always_comb begin
    st_be        = BE_NONE;
    st_wdata_rep = st_wdata;
    case (st_size)
      SIZE_BYTE: begin
        st_be        = BE_BYTE << st_offs;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      SIZE_HALF: begin
        st_be        = BE_HALF << st_offs;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      SIZE_WORD: begin
        st_be        = BE_WORD;
        st_wdata_rep = st_wdata;
      end
      default: begin
        st_be        = BE_NONE;
        st_wdata_rep = st_wdata;
      end
    endcase
  end

  // Move the addressed lane to bit 0 and extend it to a full word
  always_comb begin
    ld_shift_s = ld_word >> {ld_offs, 3'b000};
    ld_sign_s  = 1'b0;
    ld_data    = ld_shift_s;
    case (ld_size)
      SIZE_BYTE: begin
        ld_sign_s = ~ld_unsigned & ld_shift_s[7];
        ld_data   = {{24{ld_sign_s}}, ld_shift_s[7:0]};
      end
      SIZE_HALF: begin
        ld_sign_s = ~ld_unsigned & ld_shift_s[15];
        ld_data   = {{16{ld_sign_s}}, ld_shift_s[15:0]};
      end
      default: begin
        ld_sign_s = 1'b0;
        ld_data   = ld_shift_s;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between the core
// control path and a req/gnt + rvalid memory port.
// Optional feature macro: LSU_TIMEOUT_EN -- when defined, an access that
// spends TIMEOUT_CYCLES cycles in REQ+WAIT is aborted with bus_err.
// All outputs are registers; rst_n clears every one of them asynchronously.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_r;
  logic        is_store_r;
  logic [1:0]  size_r;
  logic [1:0]  offs_r;
  logic        uns_r;

  logic        busy_r;
  logic        done_r;
  logic        misaligned_r;
  logic [31:0] rdata_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [3:0]  mem_be_r;
  logic [31:0] mem_wdata_r;

  logic        req_mis_s;
  logic [3:0]  req_be_s;
  logic [31:0] req_wdata_s;
  logic [31:0] ld_data_s;

  // Store steering works on the live request (registered at acceptance);
  // load extraction works on the captured size/offset of the access.
  lsu_lane_align u_lane_align (
    .st_size      (size),
    .st_offs      (addr[1:0]),
    .st_wdata     (wdata),
    .st_be        (req_be_s),
    .st_wdata_rep (req_wdata_s),
    .ld_size      (size_r),
    .ld_offs      (offs_r),
    .ld_unsigned  (uns_r),
    .ld_word      (mem_rdata),
    .ld_data      (ld_data_s)
  );

  assign req_mis_s = lsu_misaligned(size, addr[1:0]);

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt_r;
  logic             tmo_hit_s;
  logic             bus_err_r;

  // Last REQ/WAIT cycle allowed before the access is abandoned
  assign tmo_hit_s = (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cycle counter spanning the whole REQ+WAIT interval of one access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end
  end

  assign bus_err = bus_err_r;
`else
  // Keeps the parameter referenced in builds without the abort counter
  localparam int unused_timeout_cycles_c = TIMEOUT_CYCLES;

  assign bus_err = 1'b0;
`endif

  // Control FSM; every output is updated together with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      is_store_r   <= 1'b0;
      size_r       <= 2'b00;
      offs_r       <= 2'b00;
      uns_r        <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      misaligned_r <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_be_r     <= 4'b0000;
      mem_wdata_r  <= 32'h0000_0000;
`ifdef LSU_TIMEOUT_EN
      bus_err_r    <= 1'b0;
`endif
    end else begin
      // Completion flags are single-cycle pulses
      done_r       <= 1'b0;
      misaligned_r <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err_r    <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            is_store_r <= is_store;
            size_r     <= size;
            offs_r     <= addr[1:0];
            uns_r      <= load_unsigned;
            busy_r     <= 1'b1;
            if (req_mis_s) begin
              // Rejected without touching the memory port
              state_r      <= ST_RESP;
              done_r       <= 1'b1;
              misaligned_r <= 1'b1;
            end else begin
              state_r     <= ST_REQ;
              mem_req_r   <= 1'b1;
              mem_we_r    <= is_store;
              mem_addr_r  <= {addr[31:2], 2'b00};
              mem_be_r    <= req_be_s;
              mem_wdata_r <= req_wdata_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_REQ: begin
          if (mem_gnt) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            if (is_store_r) begin
              state_r <= ST_RESP;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_WAIT;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_hit_s) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            state_r     <= ST_RESP;
            done_r      <= 1'b1;
            bus_err_r   <= 1'b1;
          end
`endif
          else begin
            state_r <= ST_REQ;
          end
        end

        ST_WAIT: begin
          if (mem_rvalid) begin
            rdata_r <= ld_data_s;
            state_r <= ST_RESP;
            done_r  <= 1'b1;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_hit_s) begin
            state_r   <= ST_RESP;
            done_r    <= 1'b1;
            bus_err_r <= 1'b1;
          end
`endif
          else begin
            state_r <= ST_WAIT;
          end
        end

        ST_RESP: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end

        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          mem_req_r   <= 1'b0;
          mem_we_r    <= 1'b0;
          mem_addr_r  <= 32'h0000_0000;
          mem_be_r    <= 4'b0000;
          mem_wdata_r <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign misaligned = misaligned_r;
  assign rdata      = rdata_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_be     = mem_be_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit.
// Stimulus pushes expected responses and bus requests into queues; two
// monitors compare them against the DUT on the falling clock edge.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, misaligned, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit #(.TIMEOUT_CYCLES((TMO > 0) ? TMO : 255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .size(size),
    .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic mis; logic berr; logic [31:0] rd; } rsp_t;
  typedef struct { logic [31:0] a; logic [3:0] be; logic [31:0] wd; logic we; } bus_t;

  rsp_t        rsp_q[$];
  bus_t        bus_q[$];
  rsp_t        rmon;
  bus_t        bmon;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          in_req = 1'b0;
  logic [31:0] model_rdata = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference rules written as plain arithmetic
  function automatic logic ref_mis(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'b11) || (sz == 2'b01 && (off % 2) == 1) || (sz == 2'b10 && off != 2'b00);
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] one, two;
    one = 4'b0001;
    two = 4'b0011;
    if (sz == 2'b00) return one << off;
    else if (sz == 2'b01) return two << off;
    else return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return {24'd0, wd[7:0]} * 32'h0101_0101;
    else if (sz == 2'b01) return {16'd0, wd[15:0]} * 32'h0001_0001;
    else return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [1:0] off,
                                           input logic un, input logic [31:0] word);
    longint v, span;
    v = longint'(word) >> (8 * int'(off));
    if (sz == 2'b00) span = 256;
    else if (sz == 2'b01) span = 65536;
    else span = 64'h1_0000_0000;
    v = v % span;
    if (!un && sz != 2'b10 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // Response monitor: every done pulse is matched to the oldest expectation
  always @(negedge clk) begin
    if (done) begin
      if (rsp_q.size() == 0) begin
        chk("done_unexpected", {31'd0, done}, 32'd0);
      end else begin
        rmon = rsp_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(rmon.cyc));
        chk("misaligned", {31'd0, misaligned}, {31'd0, rmon.mis});
        chk("bus_err", {31'd0, bus_err}, {31'd0, rmon.berr});
        chk("rdata", rdata, rmon.rd);
        chk("busy_at_done", {31'd0, busy}, 32'd1);
      end
    end else begin
      chk("flags_without_done", {30'd0, misaligned, bus_err}, 32'd0);
    end
  end

  // Bus monitor: mem_* must match the expected request on every req cycle
  always @(negedge clk) begin
    if (mem_req) begin
      if (bus_q.size() == 0) begin
        chk("mem_req_unexpected", {31'd0, mem_req}, 32'd0);
      end else begin
        bmon = bus_q[0];
        chk("mem_addr", mem_addr, bmon.a);
        chk("mem_be", 32'(mem_be), 32'(bmon.be));
        chk("mem_wdata", mem_wdata, bmon.wd);
        chk("mem_we", {31'd0, mem_we}, {31'd0, bmon.we});
      end
      in_req <= 1'b1;
    end else begin
      chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
      if (in_req && bus_q.size() > 0) void'(bus_q.pop_front());
      in_req <= 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {26'd0, busy, done, misaligned, bus_err, mem_req, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  // Issue one access in the current (idle) cycle, then play the memory side:
  // gnt after g stall cycles, rvalid w cycles after entering WAIT.
  task automatic do_op(input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int g, input int w, input logic [31:0] rd, input bit noise);
    int   t0, done_off;
    logic mis, gnt_ok, rv_ok, tmo;
    t0 = cyc;
    start = 1'b1; is_store = st; size = sz; load_unsigned = un; addr = a; wdata = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mis    = ref_mis(sz, a[1:0]);
    gnt_ok = !mis && (TMO == 0 || g + 1 <= TMO);
    rv_ok  = gnt_ok && !st && (TMO == 0 || g + 2 + w <= TMO);
    tmo    = !mis && (!gnt_ok || (!st && !rv_ok));
    if (mis) done_off = 1;
    else if (tmo) done_off = 1 + TMO;
    else if (st) done_off = g + 2;
    else done_off = g + 3 + w;
    if (!mis && !tmo && !st) model_rdata = ref_load(sz, a[1:0], un, rd);
    rsp_q.push_back('{cyc: t0 + done_off, mis: mis, berr: tmo, rd: model_rdata});
    if (!mis) bus_q.push_back('{a: {a[31:2], 2'b00}, be: ref_be(sz, a[1:0]), wd: ref_wd(sz, wd), we: st});
    for (int k = 1; k <= done_off; k++) begin
      @(posedge clk); #1;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        is_store = 1'($urandom_range(0, 1)); size = 2'($urandom_range(0, 3));
        addr = $urandom; wdata = $urandom; load_unsigned = 1'($urandom_range(0, 1));
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (gnt_ok && k == 1 + g) mem_gnt = 1'b1;
      if (rv_ok && k == 2 + g + w) begin mem_rvalid = 1'b1; mem_rdata = rd; end
      if (noise && k == done_off) begin
        mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk); #1;
    start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // Idle cycles with stray memory handshakes that must be ignored
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      start = 1'b0;
      mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Store byte to 0x1003, then signed half load from 0x2002
    do_op(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0, 1'b0);
    do_op(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h1111_2222, 0, 0, 32'h8001_1234, 1'b0);
    chk("half_signed_value", rdata, 32'hFFFF_8001);
    // Misaligned word: no bus request, rdata unchanged
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 0, 0, 32'h0, 1'b0);
    // Grant withheld for 5 cycles while start pulses and inputs churn
    do_op(1'b1, 2'b10, 1'b0, 32'h0000_5004, 32'hDEAD_BEEF, 5, 0, 32'h0, 1'b1);

    // Reset while waiting for read data
    start = 1'b1; is_store = 1'b0; size = 2'b10; load_unsigned = 1'b0;
    addr = 32'h4000_0010; wdata = 32'h0123_4567;
    bus_q.push_back('{a: 32'h4000_0010, be: 4'b1111, wd: 32'h0123_4567, we: 1'b0});
    @(posedge clk); #1; start = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    @(posedge clk); #1;
    chk("busy_in_wait", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    model_rdata = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(1'b0, 2'b00, 1'b1, 32'h0000_7003, 32'h0, 0, 1, 32'h9A00_0000, 1'b0);

    // Randomized mix including illegal sizes, offsets and stalls
    for (int i = 0; i < 300; i++) begin
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

`ifdef LSU_TIMEOUT_EN
    // No grant at all, then a load whose data never returns
    do_op(1'b1, 2'b10, 1'b0, 32'h0000_6000, 32'h5555_AAAA, 100, 0, 32'h0, 1'b0);
    do_op(1'b0, 2'b00, 1'b1, 32'h0000_6001, 32'h0, 0, 10, 32'h0, 1'b0);
`endif

    idle(3);
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
